exc_pipe: RTL and testbench

- Carries per-instruction exception sideband from ID through EXE and MEM to WB.
- Merges each stage's new exception sources in priority order, keeping the oldest (earliest-stage) exception per instruction.
- Computes delay-slot flag and EPC value, and drives the unified exception bus consumed by the CP0 block at WB.
- Also emits kill signals so younger side effects (stores, overflow writeback) are squashed once an older exception is known.

---
 rtl/exc_pipe_pkg.sv | 35 +++
 rtl/exc_stage_reg.sv | 45 ++++
 rtl/exc_pipe.sv | 192 +++++++++++++++++++
 tb/tb_exc_pipe.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_pipe_pkg
// Purpose  : ExcCodes and the exception stage-record layout shared by exc_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package exc_pipe_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] EXC_TLBL = 5'd2;
  localparam logic [CODE_W-1:0] EXC_TLBS = 5'd3;
  localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
  localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [CODE_W-1:0] EXC_BP   = 5'd9;
  localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
  localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

  // Fixed-width head of a record; the full record is {hdr, epc, bva}.
  typedef struct packed {
    logic              v;
    logic [CODE_W-1:0] code;
    logic              bd;
    logic              bv;
  } exc_hdr_t;

  localparam int HDR_W = $bits(exc_hdr_t);

  function automatic int exc_rec_w(input int pc_w);
    return HDR_W + 2 * pc_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exc_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : exc_stage_reg
// Purpose  : One pipeline exception record with load / drain / flush control.
// Revision : 1.0 - initial release
// ============================================================================
module exc_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] rec_i,
  output logic [W-1:0] rec_o
);

  logic [W-1:0] rec_d;
  logic [W-1:0] rec_q;

  // Flush beats load, load beats drain, otherwise hold across a stall.
  always_comb begin
    rec_d = rec_q;
    if (flush) begin
      rec_d = '0;
    end else if (load) begin
      rec_d = rec_i;
    end else if (drain) begin
      rec_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign rec_o = rec_q;

endmodule
`default_nettype wire

// File: rtl/exc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : exc_pipe
// Purpose  : Exception sideband pipeline ID->EXE->MEM->WB with oldest-wins merge.
// Revision : 1.0 - initial release
// ============================================================================
module exc_pipe
  import exc_pipe_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter bit TLB_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cancel,
  input  logic            id_to_exe_fire,
  input  logic            exe_to_mem_fire,
  input  logic            mem_to_wb_fire,
  input  logic            wb_over,
  input  logic [PC_W-1:0] id_pc,
  input  logic            id_is_branch,
  input  logic            id_fetch_adel,
  input  logic            id_ri,
  input  logic            id_syscall,
  input  logic            id_break,
  input  logic            exe_ov,
  input  logic            mem_adel,
  input  logic            mem_ades,
  input  logic            mem_tlbl,
  input  logic            mem_tlbs,
  input  logic [PC_W-1:0] mem_vaddr,
  output logic            ex_valid_o,
  output logic [4:0]      ex_code_o,
  output logic            ex_bd_o,
  output logic [PC_W-1:0] ex_pc_o,
  output logic            badvaddr_valid_o,
  output logic [PC_W-1:0] badvaddr_o,
  output logic            mem_kill_o,
  output logic            exe_kill_o,
  output logic            exc_pending_o
);

  localparam int REC_W = exc_rec_w(PC_W);

  logic             last_branch_d;
  logic             last_branch_q;

  logic [REC_W-1:0] id_rec;
  logic [REC_W-1:0] exe_rec_m;
  logic [REC_W-1:0] mem_rec_m;
  logic [REC_W-1:0] exe_rec_q;
  logic [REC_W-1:0] mem_rec_q;
  logic [REC_W-1:0] wb_rec_q;

  exc_hdr_t         id_hdr;
  exc_hdr_t         exe_hdr_q;
  exc_hdr_t         exe_hdr_m;
  exc_hdr_t         mem_hdr_q;
  exc_hdr_t         mem_hdr_m;
  exc_hdr_t         wb_hdr_q;
  logic [PC_W-1:0]  id_epc;
  logic [PC_W-1:0]  id_bva;
  logic [PC_W-1:0]  exe_epc_q;
  logic [PC_W-1:0]  exe_bva_q;
  logic [PC_W-1:0]  mem_epc_q;
  logic [PC_W-1:0]  mem_bva_q;
  logic [PC_W-1:0]  mem_bva_m;
  logic [PC_W-1:0]  wb_epc_q;
  logic [PC_W-1:0]  wb_bva_q;
  logic             tlbl_en;
  logic             tlbs_en;

  assign {exe_hdr_q, exe_epc_q, exe_bva_q} = exe_rec_q;
  assign {mem_hdr_q, mem_epc_q, mem_bva_q} = mem_rec_q;
  assign {wb_hdr_q,  wb_epc_q,  wb_bva_q}  = wb_rec_q;

  assign tlbl_en = TLB_EN & mem_tlbl;
  assign tlbs_en = TLB_EN & mem_tlbs;

  always_comb begin
    last_branch_d = last_branch_q;
    if (cancel) begin
      last_branch_d = 1'b0;
    end else if (id_to_exe_fire) begin
      last_branch_d = id_is_branch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_branch_q <= 1'b0;
    end else begin
      last_branch_q <= last_branch_d;
    end
  end

  // bd and epc travel with every instruction so later stages can raise on it.
  always_comb begin
    id_hdr    = '0;
    id_hdr.bd = last_branch_q;
    id_bva    = '0;
    id_epc    = last_branch_q ? (id_pc - PC_W'(4)) : id_pc;
    if (id_fetch_adel) begin
      id_hdr.v    = 1'b1;
      id_hdr.code = EXC_ADEL;
      id_hdr.bv   = 1'b1;
      id_bva      = id_pc;
    end else if (id_ri) begin
      id_hdr.v    = 1'b1;
      id_hdr.code = EXC_RI;
    end else if (id_syscall) begin
      id_hdr.v    = 1'b1;
      id_hdr.code = EXC_SYS;
    end else if (id_break) begin
      id_hdr.v    = 1'b1;
      id_hdr.code = EXC_BP;
    end
    id_rec = {id_hdr, id_epc, id_bva};
  end

  always_comb begin
    exe_hdr_m = exe_hdr_q;
    if (!exe_hdr_q.v && exe_ov) begin
      exe_hdr_m.v    = 1'b1;
      exe_hdr_m.code = EXC_OV;
    end
    exe_rec_m = {exe_hdr_m, exe_epc_q, exe_bva_q};
  end

  always_comb begin
    mem_hdr_m = mem_hdr_q;
    mem_bva_m = mem_bva_q;
    if (!mem_hdr_q.v && (mem_adel || mem_ades || tlbl_en || tlbs_en)) begin
      mem_hdr_m.v  = 1'b1;
      mem_hdr_m.bv = 1'b1;
      mem_bva_m    = mem_vaddr;
      if (mem_adel) begin
        mem_hdr_m.code = EXC_ADEL;
      end else if (mem_ades) begin
        mem_hdr_m.code = EXC_ADES;
      end else if (tlbl_en) begin
        mem_hdr_m.code = EXC_TLBL;
      end else begin
        mem_hdr_m.code = EXC_TLBS;
      end
    end
    mem_rec_m = {mem_hdr_m, mem_epc_q, mem_bva_m};
  end

  exc_stage_reg #(.W(REC_W)) u_exe_reg (
    .clk   (clk),
    .reset (reset),
    .flush (cancel),
    .load  (id_to_exe_fire),
    .drain (exe_to_mem_fire),
    .rec_i (id_rec),
    .rec_o (exe_rec_q)
  );

  exc_stage_reg #(.W(REC_W)) u_mem_reg (
    .clk   (clk),
    .reset (reset),
    .flush (cancel),
    .load  (exe_to_mem_fire),
    .drain (mem_to_wb_fire),
    .rec_i (exe_rec_m),
    .rec_o (mem_rec_q)
  );

  exc_stage_reg #(.W(REC_W)) u_wb_reg (
    .clk   (clk),
    .reset (reset),
    .flush (cancel),
    .load  (mem_to_wb_fire),
    .drain (wb_over),
    .rec_i (mem_rec_m),
    .rec_o (wb_rec_q)
  );

  assign ex_valid_o       = wb_hdr_q.v;
  assign ex_code_o        = wb_hdr_q.v ? wb_hdr_q.code : '0;
  assign ex_bd_o          = wb_hdr_q.v & wb_hdr_q.bd;
  assign ex_pc_o          = wb_hdr_q.v ? wb_epc_q : '0;
  assign badvaddr_valid_o = wb_hdr_q.v & wb_hdr_q.bv;
  assign badvaddr_o       = wb_hdr_q.v ? wb_bva_q : '0;

  assign mem_kill_o    = wb_hdr_q.v | mem_hdr_q.v | mem_hdr_m.v;
  assign exe_kill_o    = mem_kill_o | exe_hdr_q.v | exe_ov;
  assign exc_pending_o = exe_hdr_q.v | mem_hdr_q.v | wb_hdr_q.v;

endmodule
`default_nettype wire

// File: tb/tb_exc_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_pipe
// Purpose  : Directed + randomized checks of exc_pipe against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_pipe;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            cancel;
  logic            id_to_exe_fire, exe_to_mem_fire, mem_to_wb_fire, wb_over;
  logic [PC_W-1:0] id_pc;
  logic            id_is_branch, id_fetch_adel, id_ri, id_syscall, id_break;
  logic            exe_ov;
  logic            mem_adel, mem_ades, mem_tlbl, mem_tlbs;
  logic [PC_W-1:0] mem_vaddr;
  logic            ex_valid_o;
  logic [4:0]      ex_code_o;
  logic            ex_bd_o;
  logic [PC_W-1:0] ex_pc_o;
  logic            badvaddr_valid_o;
  logic [PC_W-1:0] badvaddr_o;
  logic            mem_kill_o, exe_kill_o, exc_pending_o;

  exc_pipe #(.PC_W(PC_W), .TLB_EN(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .cancel           (cancel),
    .id_to_exe_fire   (id_to_exe_fire),
    .exe_to_mem_fire  (exe_to_mem_fire),
    .mem_to_wb_fire   (mem_to_wb_fire),
    .wb_over          (wb_over),
    .id_pc            (id_pc),
    .id_is_branch     (id_is_branch),
    .id_fetch_adel    (id_fetch_adel),
    .id_ri            (id_ri),
    .id_syscall       (id_syscall),
    .id_break         (id_break),
    .exe_ov           (exe_ov),
    .mem_adel         (mem_adel),
    .mem_ades         (mem_ades),
    .mem_tlbl         (mem_tlbl),
    .mem_tlbs         (mem_tlbs),
    .mem_vaddr        (mem_vaddr),
    .ex_valid_o       (ex_valid_o),
    .ex_code_o        (ex_code_o),
    .ex_bd_o          (ex_bd_o),
    .ex_pc_o          (ex_pc_o),
    .badvaddr_valid_o (badvaddr_valid_o),
    .badvaddr_o       (badvaddr_o),
    .mem_kill_o       (mem_kill_o),
    .exe_kill_o       (exe_kill_o),
    .exc_pending_o    (exc_pending_o)
  );

  always #5 clk = ~clk;

  // Each in-flight instruction keeps every raw event seen so far; the
  // architectural exception is derived only when the outputs are examined.
  typedef struct packed {
    logic [31:0] pc;
    logic        bd;
    logic        fadel, ri, sys, brk;
    logic        ov;
    logic        adel, ades, tlbl, tlbs;
    logic [31:0] va;
  } ins_t;

  ins_t se, sm, sw;
  logic lb;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exc_code(input ins_t s);
    if (s.fadel) return 4;
    if (s.ri)    return 10;
    if (s.sys)   return 8;
    if (s.brk)   return 9;
    if (s.ov)    return 12;
    if (s.adel)  return 4;
    if (s.ades)  return 5;
    if (s.tlbl)  return 2;
    if (s.tlbs)  return 3;
    return -1;
  endfunction

  function automatic bit has_exc(input ins_t s);
    return exc_code(s) >= 0;
  endfunction

  function automatic bit bv_of(input ins_t s);
    if (s.fadel) return 1'b1;
    if (s.ri || s.sys || s.brk || s.ov) return 1'b0;
    return s.adel || s.ades || s.tlbl || s.tlbs;
  endfunction

  function automatic logic [31:0] bva_of(input ins_t s);
    if (!bv_of(s)) return 32'h0;
    return s.fadel ? s.pc : s.va;
  endfunction

  function automatic ins_t with_mem(input ins_t s);
    ins_t r = s;
    r.adel = mem_adel;
    r.ades = mem_ades;
    r.tlbl = mem_tlbl;
    r.tlbs = mem_tlbs;
    r.va   = mem_vaddr;
    return r;
  endfunction

  task automatic check_outputs();
    int          c  = exc_code(sw);
    bit          v  = (c >= 0);
    ins_t        mm = with_mem(sm);
    logic [31:0] epc;
    bit          mk;
    epc = sw.bd ? (sw.pc - 32'd4) : sw.pc;
    mk  = has_exc(sw) || has_exc(mm);
    check("ex_valid", {31'b0, ex_valid_o}, {31'b0, v});
    check("ex_code",  {27'b0, ex_code_o}, v ? c : 0);
    check("ex_bd",    {31'b0, ex_bd_o}, {31'b0, v && sw.bd});
    check("ex_pc",    ex_pc_o, v ? epc : 32'h0);
    check("bv_valid", {31'b0, badvaddr_valid_o}, {31'b0, v && bv_of(sw)});
    check("badvaddr", badvaddr_o, v ? bva_of(sw) : 32'h0);
    check("mem_kill", {31'b0, mem_kill_o}, {31'b0, mk});
    check("exe_kill", {31'b0, exe_kill_o}, {31'b0, mk || has_exc(se) || exe_ov});
    check("pending",  {31'b0, exc_pending_o}, {31'b0, has_exc(se) || has_exc(sm) || has_exc(sw)});
  endtask

  task automatic model_clear();
    se = '0;
    sm = '0;
    sw = '0;
    lb = 1'b0;
  endtask

  task automatic model_update();
    ins_t ni, ne, nm, nw;
    if (cancel) begin
      model_clear();
      return;
    end
    ni       = '0;
    ni.pc    = id_pc;
    ni.bd    = lb;
    ni.fadel = id_fetch_adel;
    ni.ri    = id_ri;
    ni.sys   = id_syscall;
    ni.brk   = id_break;
    nw = mem_to_wb_fire  ? with_mem(sm) : (wb_over ? '0 : sw);
    nm = sm;
    if (exe_to_mem_fire) begin
      nm    = se;
      nm.ov = exe_ov;
    end else if (mem_to_wb_fire) begin
      nm = '0;
    end
    ne = id_to_exe_fire ? ni : (exe_to_mem_fire ? '0 : se);
    if (id_to_exe_fire) lb = id_is_branch;
    se = ne;
    sm = nm;
    sw = nw;
  endtask

  task automatic clear_inputs();
    cancel = 0; id_to_exe_fire = 0; exe_to_mem_fire = 0; mem_to_wb_fire = 0; wb_over = 0;
    id_pc = '0; id_is_branch = 0; id_fetch_adel = 0; id_ri = 0; id_syscall = 0; id_break = 0;
    exe_ov = 0; mem_adel = 0; mem_ades = 0; mem_tlbl = 0; mem_tlbs = 0; mem_vaddr = '0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1 check_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic rand_inputs();
    cancel          = ($urandom_range(0, 31) == 0);
    id_to_exe_fire  = $urandom_range(0, 3) != 0;
    exe_to_mem_fire = $urandom_range(0, 3) != 0;
    mem_to_wb_fire  = $urandom_range(0, 3) != 0;
    wb_over         = $urandom_range(0, 2) != 0;
    id_pc           = $urandom;
    id_is_branch    = ($urandom_range(0, 3) == 0);
    id_fetch_adel   = ($urandom_range(0, 11) == 0);
    id_ri           = ($urandom_range(0, 11) == 0);
    id_syscall      = ($urandom_range(0, 11) == 0);
    id_break        = ($urandom_range(0, 11) == 0);
    exe_ov          = ($urandom_range(0, 9) == 0);
    mem_adel        = ($urandom_range(0, 11) == 0);
    mem_ades        = ($urandom_range(0, 11) == 0);
    mem_tlbl        = ($urandom_range(0, 11) == 0);
    mem_tlbs        = ($urandom_range(0, 11) == 0);
    mem_vaddr       = $urandom;
  endtask

  initial begin
    clear_inputs();
    model_clear();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_outputs();
    reset = 1'b0;
    @(negedge clk);

    // syscall at 0x1000, not in a delay slot
    id_pc = 32'h1000; id_syscall = 1; id_to_exe_fire = 1; cycle();
    exe_to_mem_fire = 1; cycle();
    mem_to_wb_fire = 1; cycle();
    #1;
    check("sys_code", {27'b0, ex_code_o}, 32'd8);
    check("sys_pc", ex_pc_o, 32'h1000);
    check("sys_bv", {31'b0, badvaddr_valid_o}, 32'd0);
    wb_over = 1; cycle();

    // branch at 0x2000, delay slot at 0x2004 faults with AdES
    id_pc = 32'h2000; id_is_branch = 1; id_to_exe_fire = 1; cycle();
    id_pc = 32'h2004; id_to_exe_fire = 1; exe_to_mem_fire = 1; cycle();
    exe_to_mem_fire = 1; mem_to_wb_fire = 1; cycle();
    wb_over = 1; mem_ades = 1; mem_vaddr = 32'h3001; mem_to_wb_fire = 1;
    #1 check("ds_mem_kill", {31'b0, mem_kill_o}, 32'd1);
    cycle();
    #1;
    check("ds_code", {27'b0, ex_code_o}, 32'd5);
    check("ds_bd", {31'b0, ex_bd_o}, 32'd1);
    check("ds_pc", ex_pc_o, 32'h2000);
    check("ds_bva", badvaddr_o, 32'h3001);
    wb_over = 1; cycle();

    // RI + Ov + AdEL on one instruction: decode exception wins
    id_pc = 32'h4000; id_ri = 1; id_to_exe_fire = 1; cycle();
    exe_ov = 1; exe_to_mem_fire = 1; cycle();
    mem_adel = 1; mem_vaddr = 32'h5; mem_to_wb_fire = 1; cycle();
    #1;
    check("old_code", {27'b0, ex_code_o}, 32'd10);
    check("old_bv", {31'b0, badvaddr_valid_o}, 32'd0);
    wb_over = 1; cycle();

    // stall with an exception parked in EXE
    id_pc = 32'h4100; id_break = 1; id_to_exe_fire = 1; cycle();
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_pend", {31'b0, exc_pending_o}, 32'd1);
      cycle();
    end
    exe_to_mem_fire = 1; cycle();
    mem_to_wb_fire = 1; cycle();
    wb_over = 1; cycle();
    #1 check("drained_pend", {31'b0, exc_pending_o}, 32'd0);

    // cancel together with a branch entering EXE
    id_pc = 32'h5ff0; id_ri = 1; id_to_exe_fire = 1; cycle();
    id_pc = 32'h6000; id_is_branch = 1; id_to_exe_fire = 1; cancel = 1; cycle();
    #1 check("cancel_pend", {31'b0, exc_pending_o}, 32'd0);
    id_pc = 32'h6004; id_syscall = 1; id_to_exe_fire = 1; cycle();
    exe_to_mem_fire = 1; cycle();
    mem_to_wb_fire = 1; cycle();
    #1;
    check("post_cancel_bd", {31'b0, ex_bd_o}, 32'd0);
    check("post_cancel_pc", ex_pc_o, 32'h6004);

    // asynchronous reset while WB holds a valid record
    #2 reset = 1'b1;
    #1 check("async_rst_valid", {31'b0, ex_valid_o}, 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();

    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
